// File: rtl/water_level_sensor_conditioner.sv
// Water level sensor conditioner.
// Cleans up the three raw tank probes (low / medium / high) for the valve
// controller. It does three things:
//   - synchronises each probe through two flops,
//   - debounces each probe,
//   - flags physically impossible probe combinations.
// The conflict flag is fail-safe. It is high from reset until the probes
// have settled, and after a conflict it stays high for a full clean
// recovery window.
// reset_n asserts asynchronously. Its release is expected to be
// synchronised to clock upstream.
module water_level_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CLEAR_CYCLES    = 32,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   low_sensor,
    input  logic                   medium_sensor,
    input  logic                   high_sensor,
    output logic                   low_water_level,
    output logic                   medium_water_level,
    output logic                   high_water_level,
    output logic                   water_sensors_conflicting,
    output logic [COUNT_WIDTH-1:0] fault_count
);

    localparam int DW            = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SETTLE_CYCLES = DEBOUNCE_CYCLES + 2;
    localparam int TIMER_MAX     = (CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES;
    localparam int TW            = $clog2(TIMER_MAX);

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] CLEAR_LAST  = TW'(CLEAR_CYCLES - 1);

    // Conflict FSM encoding; all four codes are in use.
    localparam logic [1:0] SETTLING   = 2'b00;
    localparam logic [1:0] NORMAL     = 2'b01;
    localparam logic [1:0] FAULT      = 2'b10;
    localparam logic [1:0] RECOVERING = 2'b11;

    // Probe bit order everywhere: [0] = low, [1] = medium, [2] = high.
    logic [2:0] probe_raw;
    logic [2:0] sync_meta;
    logic [2:0] sync_q;
    logic [2:0] level;

    assign probe_raw = {high_sensor, medium_sensor, low_sensor};

    // Two-flop synchroniser for the asynchronous probe inputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= probe_raw;
            sync_q    <= sync_meta;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_debounce
            logic [DW-1:0] cnt;
            logic          stable;

            // Accept a new probe value only after it has differed from the
            // stable value for DEBOUNCE_CYCLES consecutive synced samples.
            // Any agreeing sample restarts the count.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    cnt    <= '0;
                    stable <= 1'b0;
                end else if (sync_q[g] != stable) begin
                    if (cnt == DEB_LAST) begin
                        stable <= sync_q[g];
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end

            assign level[g] = stable;
        end
    endgenerate

    assign low_water_level    = level[0];
    assign medium_water_level = level[1];
    assign high_water_level   = level[2];

    // Water above a probe implies water at every probe below it.
    logic raw_conflict;
    assign raw_conflict = (level[2] & ~level[1]) | (level[1] & ~level[0]);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          fault_inc;

    // Next-state logic for the conflict FSM.
    // Only a NORMAL -> FAULT entry counts as a fault.
    always_comb begin
        state_next = state;
        timer_next = timer;
        fault_inc  = 1'b0;
        case (state)
            SETTLING: begin
                if (timer == SETTLE_LAST) begin
                    timer_next = '0;
                    state_next = raw_conflict ? FAULT : NORMAL;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            NORMAL: begin
                if (raw_conflict) begin
                    state_next = FAULT;
                    fault_inc  = 1'b1;
                end
            end
            FAULT: begin
                if (!raw_conflict) begin
                    state_next = RECOVERING;
                    timer_next = '0;
                end
            end
            RECOVERING: begin
                if (raw_conflict) begin
                    state_next = FAULT;
                end else if (timer == CLEAR_LAST) begin
                    state_next = NORMAL;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: begin
                state_next = SETTLING;
                timer_next = '0;
            end
        endcase
    end

    // State, timer, registered conflict flag and saturating fault counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                     <= SETTLING;
            timer                     <= '0;
            water_sensors_conflicting <= 1'b1;
            fault_count               <= '0;
        end else begin
            state                     <= state_next;
            timer                     <= timer_next;
            water_sensors_conflicting <= (state_next != NORMAL);
            if (fault_inc && (fault_count != {COUNT_WIDTH{1'b1}})) begin
                fault_count <= fault_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_water_level_sensor_conditioner.sv
// Bench for water_level_sensor_conditioner (DEBOUNCE_CYCLES=4, CLEAR_CYCLES=8).
// The reference model describes behaviour, not structure:
//   - A probe level flips once the raw probe, seen two samples late, has
//     disagreed with the level for DEBOUNCE_CYCLES samples in a row.
//   - The flag is high while settling. It rises on a conflict.
//   - After a rise, the flag needs CLEAR_CYCLES+1 clean samples in a row
//     before it drops.
module tb_water_level_sensor_conditioner;

    localparam int DEB    = 4;
    localparam int CLR    = 8;
    localparam int CW     = 8;
    localparam int SATMAX = (1 << CW) - 1;

    logic          clock         = 1'b0;
    logic          reset_n       = 1'b1;
    logic          low_sensor    = 1'b0;
    logic          medium_sensor = 1'b0;
    logic          high_sensor   = 1'b0;
    logic          low_water_level;
    logic          medium_water_level;
    logic          high_water_level;
    logic          water_sensors_conflicting;
    logic [CW-1:0] fault_count;

    water_level_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CLEAR_CYCLES   (CLR),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .low_sensor               (low_sensor),
        .medium_sensor            (medium_sensor),
        .high_sensor              (high_sensor),
        .low_water_level          (low_water_level),
        .medium_water_level       (medium_water_level),
        .high_water_level         (high_water_level),
        .water_sensors_conflicting(water_sensors_conflicting),
        .fault_count              (fault_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [2:0] lvl_obs;
    assign lvl_obs = {high_water_level, medium_water_level, low_water_level};

    // Reference model state.
    logic [2:0] raw_cur;
    logic [2:0] hist[$];
    logic [2:0] m_lv;
    int         m_edges;
    bit         m_settling;
    bit         m_flag;
    int         m_clean;
    int         m_faults;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(3'b000);
        m_lv       = 3'b000;
        m_edges    = 0;
        m_settling = 1'b1;
        m_flag     = 1'b1;
        m_clean    = 0;
        m_faults   = 0;
    endtask

    task automatic model_edge();
        logic rc;
        bit   all_diff;
        rc = (m_lv[2] & ~m_lv[1]) | (m_lv[1] & ~m_lv[0]);
        m_edges++;
        if (m_settling) begin
            if (m_edges == DEB + 2) begin
                m_settling = 1'b0;
                m_flag     = rc;
                m_clean    = 0;
            end
        end else if (!m_flag) begin
            if (rc) begin
                m_flag  = 1'b1;
                m_clean = 0;
                if (m_faults < SATMAX) m_faults++;
            end
        end else if (rc) begin
            m_clean = 0;
        end else begin
            m_clean++;
            if (m_clean == CLR + 1) m_flag = 1'b0;
        end
        hist.push_back(raw_cur);
        if (hist.size() > DEB + 4) void'(hist.pop_front());
        for (int i = 0; i < 3; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (hist[hist.size() - 3 - j][i] == m_lv[i]) all_diff = 1'b0;
            end
            if (all_diff) m_lv[i] = ~m_lv[i];
        end
    endtask

    task automatic check_outputs();
        chk("low_level",    low_water_level,           m_lv[0]);
        chk("medium_level", medium_water_level,        m_lv[1]);
        chk("high_level",   high_water_level,          m_lv[2]);
        chk("conflict",     water_sensors_conflicting, m_flag);
        chk("fault_count",  fault_count,               m_faults);
    endtask

    // One clock: drive raw_cur, advance the model on the edge, then compare.
    task automatic tick();
        low_sensor    = raw_cur[0];
        medium_sensor = raw_cur[1];
        high_sensor   = raw_cur[2];
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic hold(input logic [2:0] pattern, input int n);
        raw_cur = pattern;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ticks until the selected output reaches target (sel 0..2 = level, 3 = flag),
    // bounded at 40 ticks, and checks how many ticks it took.
    task automatic measure(input string tag, input int sel, input logic target, input int exp_lat);
        int   n;
        bit   hit;
        logic v;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 40) begin
            tick();
            n++;
            v = (sel == 3) ? water_sensors_conflicting : lvl_obs[sel];
            if (v === target) hit = 1'b1;
        end
        if (!hit) n = -1;
        chk(tag, n, exp_lat);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_flag"},  water_sensors_conflicting, 1);
        chk({tag, "_levels"}, lvl_obs,                  0);
        chk({tag, "_count"}, fault_count,               0);
    endtask

    initial begin
        int saved;
        raw_cur = 3'b000;
        model_reset();

        // Power-on reset.
        #1 reset_n = 1'b0;
        #1 check_reset_values("reset");
        #21 reset_n = 1'b1;

        // Settling with all probes dry: flag drops after DEB+2 cycles.
        measure("settle_flag_drop", 3, 1'b0, DEB + 2);
        hold(3'b000, 4);

        // Low-probe glitches of 1..3 cycles, plus two 3-cycle glitches
        // separated by one clean sample: no level change.
        for (int w = 1; w <= 3; w++) begin
            hold(3'b001, w);
            hold(3'b000, 8);
        end
        hold(3'b001, 3);
        hold(3'b000, 1);
        hold(3'b001, 3);
        hold(3'b000, 8);

        // Clean low edge: level follows 2+DEB cycles later, no conflict.
        raw_cur = 3'b001;
        measure("low_rise_latency", 0, 1'b1, DEB + 2);
        hold(3'b001, 4);

        // High without medium: conflict one cycle after the level is accepted.
        raw_cur = 3'b101;
        measure("high_rise_latency", 2, 1'b1, DEB + 2);
        measure("flag_rise_after_high", 3, 1'b1, 1);
        chk("first_fault_count", fault_count, 1);

        // Medium fills in: flag drops CLEAR+1 cycles after medium is accepted.
        raw_cur = 3'b111;
        measure("medium_rise_latency", 1, 1'b1, DEB + 2);
        measure("flag_drop_after_recovery", 3, 1'b0, CLR + 1);

        // Recovery interrupted by a fresh conflict: flag holds, count does not move.
        raw_cur = 3'b101;
        measure("flag_rise_medium_drop", 3, 1'b1, DEB + 3);
        chk("second_fault_count", fault_count, 2);
        hold(3'b111, 4);
        hold(3'b101, 8);
        chk("interrupt_flag_held", water_sensors_conflicting, 1);
        chk("interrupt_count_held", fault_count, 2);
        raw_cur = 3'b111;
        measure("flag_drop_after_interrupt", 3, 1'b0, DEB + 2 + CLR + 1);

        // Asynchronous reset in the middle of a fault.
        raw_cur = 3'b101;
        measure("flag_rise_before_reset", 3, 1'b1, DEB + 3);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_reset");
        model_reset();
        raw_cur       = 3'b000;
        low_sensor    = 1'b0;
        medium_sensor = 1'b0;
        high_sensor   = 1'b0;
        #20 reset_n = 1'b1;
        measure("resettle_flag_drop", 3, 1'b0, DEB + 2);

        // Random probe patterns with random hold times.
        for (int k = 0; k < 400; k++) begin
            hold(3'($urandom_range(0, 7)), $urandom_range(1, 10));
        end

        // Fault counter saturation: drive more than 2^CW faults.
        hold(3'b111, 30);
        for (int k = 0; k < SATMAX + 5; k++) begin
            hold(3'b101, 7);
            hold(3'b111, 17);
        end
        saved = int'(fault_count);
        chk("fault_count_saturated", saved, SATMAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
